// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//   APB3 completer wrapping a small word-addressed register memory. Word 0 is
//   a read-only ID register. Each transfer gets a run-time programmable number
//   of wait states (wait_cfg, sampled in the setup cycle). Misaligned,
//   out-of-range and ID-write accesses complete with pslverr=1.
//
// Ports
//   pclk, preset_n      : APB clock, asynchronous active-low reset
//   paddr, psel,
//   penable, pwrite,
//   pwdata              : APB requester inputs
//   prdata, pready,
//   pslverr             : APB completer outputs (all registered)
//   wait_cfg            : wait states for the next transfer
//   busy                : high while the FSM is in ACCESS (state visibility)
//
// Handshake: a transfer is sampled in IDLE on an edge with psel=1,
// penable=0. pready rises after wait_cfg access cycles and stays high for
// exactly one cycle; the edge with psel=1, penable=1, pready=1 completes
// the transfer (and commits a good write). psel=0 in ACCESS aborts with no
// commit.
// ---------------------------------------------------------------------------
module apb_mem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] ID_VALUE  = 32'hA9B0_0001
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic [3:0]  wait_cfg,
    output logic        busy
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]    state_q;
    logic [AW-1:0] idx_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [3:0]    cnt_q;
    logic [31:0]   mem [DEPTH];

    // Setup-cycle decode, straight from the bus. The offset is a full 32-bit
    // difference so addresses below BASE_ADDR wrap high and fail the range
    // check.
    logic [31:0]   offset;
    logic [AW-1:0] setup_idx;
    logic          setup_err;
    logic [31:0]   setup_rdata;
    logic [31:0]   held_rdata;
    logic          setup;

    always_comb begin
        offset      = paddr - BASE_ADDR;
        setup_idx   = offset[AW+1:2];
        setup_err   = (paddr[1:0] != 2'b00) | (offset >= SPAN) |
                      (pwrite & (setup_idx == '0));
        setup_rdata = '0;
        if (!setup_err && !pwrite)
            setup_rdata = (setup_idx == '0) ? ID_VALUE : mem[setup_idx];
        held_rdata  = '0;
        if (!err_q && !write_q)
            held_rdata = (idx_q == '0) ? ID_VALUE : mem[idx_q];
        setup       = psel & ~penable;
    end

    assign busy = (state_q == ACCESS);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            prdata  <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        idx_q   <= setup_idx;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        err_q   <= setup_err;
                        cnt_q   <= wait_cfg;
                        state_q <= ACCESS;
                        // Zero wait states: respond in the first access cycle.
                        if (wait_cfg == 4'd0) begin
                            pready  <= 1'b1;
                            pslverr <= setup_err;
                            prdata  <= setup_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Requester abandoned the transfer: no commit.
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                        state_q <= IDLE;
                    end else if (!pready) begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= err_q;
                            prdata  <= held_rdata;
                        end
                    end else if (penable) begin
                        if (write_q && !err_q)
                            mem[idx_q] <= wdata_q;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                        prdata  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_slave
//   Directed bench for apb_mem_slave (BASE_ADDR=0x4000_0000, DEPTH=16).
//   Inputs change 1ns after the rising edge; outputs are sampled on the
//   falling edge.
// ---------------------------------------------------------------------------
module tb_apb_mem_slave;

    localparam logic [31:0] B  = 32'h4000_0000;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        pclk;
    logic        preset_n;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  wait_cfg;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];

    apb_mem_slave #(
        .BASE_ADDR(B),
        .DEPTH    (16),
        .ID_VALUE (ID)
    ) dut (
        .pclk    (pclk),
        .preset_n(preset_n),
        .paddr   (paddr),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .wait_cfg(wait_cfg),
        .busy    (busy)
    );

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- driver ----------------
    // Call just after a rising edge. Leaves the bus idle just after the
    // completion edge, so a following call is a back-to-back setup.
    task automatic xfer(input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] wc,
                        output logic [31:0] rd, output logic er,
                        output int waits, output int busy_n);
        logic done;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
        pwdata = wd; wait_cfg = wc;
        waits = 0; busy_n = 0; rd = '0; er = 1'b0; done = 1'b0;
        @(posedge pclk); #1;
        penable  = 1'b1;
        wait_cfg = ~wc;  // must not affect the transfer in flight
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (busy) busy_n++;
            if (pready) begin
                rd = prdata; er = pslverr; done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge pclk); #1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL xfer_timeout: addr=%h no pready within 40 cycles, required pready=1", addr);
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge pclk);
        n_cmp++; if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", prdata); end
        n_cmp++; if (pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b want 0", pready); end
        n_cmp++; if (pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b want 0", pslverr); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_no_setup();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; paddr = B + 32'h8; pwrite = 1'b0; wait_cfg = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            n_cmp++; if (pready !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL no_setup: pready=%b busy=%b want 0 0", pready, busy);
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_wait0();
        logic [31:0] rd; logic er; int w, bn;
        xfer(B + 32'h8, 1'b1, 32'hDEAD_BEEF, 4'd0, rd, er, w, bn);
        n_cmp++; if (w !== 0) begin n_fail++; $display("FAIL w0_write_waits: got %0d want 0", w); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL w0_write_err: got %b want 0", er); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL w0_write_prdata: got %h want 0", rd); end
        xfer(B + 32'h8, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (w !== 0) begin n_fail++; $display("FAIL w0_read_waits: got %0d want 0", w); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL w0_read_data: got %h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL w0_read_err: got %b want 0", er); end
    endtask

    task automatic test_wait3_id();
        logic [31:0] rd; logic er; int w, bn;
        xfer(B, 1'b0, 32'h0, 4'd3, rd, er, w, bn);
        n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL w3_waits: got %0d want 3", w); end
        n_cmp++; if (bn !== 4) begin n_fail++; $display("FAIL w3_busy_cycles: got %0d want 4", bn); end
        n_cmp++; if (rd !== ID) begin n_fail++; $display("FAIL w3_id: got %h want %h", rd, ID); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL w3_err: got %b want 0", er); end
        @(negedge pclk);
        n_cmp++; if (busy !== 1'b0 || pready !== 1'b0) begin
            n_fail++; $display("FAIL w3_after: busy=%b pready=%b want 0 0", busy, pready);
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int w, bn;
        xfer(B, 1'b1, 32'h1234, 4'd0, rd, er, w, bn);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_wr_id: pslverr=%b want 1", er); end
        xfer(B + 32'h40, 1'b1, 32'h1234, 4'd1, rd, er, w, bn);
        n_cmp++; if (er !== 1'b1 || w !== 1) begin n_fail++; $display("FAIL err_wr_range: pslverr=%b waits=%0d want 1 1", er, w); end
        xfer(B, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (rd !== ID || er !== 1'b0) begin n_fail++; $display("FAIL err_id_intact: got %h/%b want %h/0", rd, er, ID); end
        xfer(B + 32'h40, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL err_rd_range: got %h/%b want 0/1", rd, er); end
        xfer(B + 32'h6, 1'b0, 32'h0, 4'd2, rd, er, w, bn);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL err_rd_misalign: got %h/%b want 0/1", rd, er); end
        xfer(B - 32'h4, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++; $display("FAIL err_rd_wrap: got %h/%b want 0/1", rd, er); end
        // word 2 must be untouched by the errored accesses
        xfer(B + 32'h8, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL err_word2_intact: got %h/%b want deadbeef/0", rd, er); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er; int w, bn;
        psel = 1'b1; penable = 1'b0; paddr = B + 32'h4; pwrite = 1'b1;
        pwdata = 32'h55; wait_cfg = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) begin @(posedge pclk); #1; end
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        n_cmp++; if (busy !== 1'b1 || pready !== 1'b0) begin n_fail++; $display("FAIL abort_before: busy=%b pready=%b want 1 0", busy, pready); end
        @(posedge pclk); #1;
        @(negedge pclk);
        n_cmp++; if (busy !== 1'b0 || pready !== 1'b0) begin n_fail++; $display("FAIL abort_after: busy=%b pready=%b want 0 0", busy, pready); end
        @(posedge pclk); #1;
        xfer(B + 32'h4, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL abort_nocommit: got %h/%b want 0/0", rd, er); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int w, bn;
        psel = 1'b1; penable = 1'b0; paddr = B + 32'h4; pwrite = 1'b1;
        pwdata = 32'h55; wait_cfg = 4'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) begin @(posedge pclk); #1; end
        preset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_outs: pready=%b pslverr=%b prdata=%h want 0 0 0", pready, pslverr, prdata);
        end
        psel = 1'b0; penable = 1'b0;
        #1 preset_n = 1'b1;
        @(posedge pclk); #1;
        xfer(B + 32'h8, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_cleared: word2 got %h want 0", rd); end
        xfer(B + 32'h4, 1'b0, 32'h0, 4'd0, rd, er, w, bn);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_nocommit: word1 got %h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [31:0] v; logic [31:0] e; logic er; int w, bn;
        for (int k = 1; k < 8; k += 2) begin
            v = 32'hC0DE_0000 | (32'(k) << 8) | 32'(k * 3);
            exp_q.push_back(v);
            xfer(B + 32'(k * 4), 1'b1, v, 4'd1, rd, er, w, bn);
            n_cmp++; if (er !== 1'b0 || w !== 1) begin n_fail++; $display("FAIL b2b_write_%0d: err=%b waits=%0d want 0 1", k, er, w); end
            xfer(B + 32'(k * 4), 1'b0, 32'h0, 4'd1, rd, er, w, bn);
            e = exp_q.pop_front();
            n_cmp++; if (rd !== e || er !== 1'b0 || w !== 1) begin
                n_fail++; $display("FAIL b2b_read_%0d: got %h/%b/%0d want %h/0/1", k, rd, er, w, e);
            end
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        preset_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0;
        pwrite = 1'b0; pwdata = '0; wait_cfg = '0;
        repeat (3) @(posedge pclk);
        test_reset();
        #2 preset_n = 1'b1;
        @(posedge pclk); #1;
        test_no_setup();
        test_wait0();
        test_wait3_id();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
